puf_resp_sequencer: RTL
=======================

PUF_RESP_SEQUENCER -- requirements
Module: puf_resp_sequencer

Interface
REQ-001 SHALL have parameter NUM_BUF, default 4: number of 8-bit buffer registers sequenced (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 255: idle cycles allowed between bytes in COLLECT before abort (1..65535).
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 clr  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request to capture one response; sampled only in IDLE.
REQ-006 byte_in  input  8  response byte from PUF source.
REQ-007 byte_valid  input  1  byte_in valid.
REQ-008 byte_ready  output  1  sequencer accepts byte; transfer = byte_valid & byte_ready.
REQ-009 buf_d  output  8  shared data bus to all buffer D inputs.
REQ-010 buf_ld  output  NUM_BUF  one-hot load strobes, bit i to buffer i.
REQ-011 buf_clr  output  1  clear strobe to all buffers.
REQ-012 rsp_valid  output  1  all buffers hold a complete response.
REQ-013 rsp_ack  input  1  consumer has taken the response.
REQ-014 busy  output  1  state != IDLE.
REQ-015 err  output  1  one-cycle pulse on timeout abort.

Function
REQ-016 States SHALL be IDLE, CLEAR, COLLECT, SETTLE, HOLD, ABORT.
REQ-017 IDLE: start=1 -> CLEAR; otherwise stay; start in any other state SHALL be ignored.
REQ-018 CLEAR: buf_clr=1 for exactly one cycle; byte index and timeout counter zeroed; -> COLLECT.
REQ-019 COLLECT: byte_ready=1 (decoded from state register only, no input-to-output path).
REQ-020 On transfer: buf_d registers byte_in and buf_ld[idx] is 1 in the next cycle only; idx increments.
REQ-021 Transfer of byte index NUM_BUF-1 SHALL move to SETTLE; byte 0 goes to buffer 0, ascending.
REQ-022 SETTLE: lasts one cycle (final buf_ld pulse issues here) -> HOLD; byte_ready=0.
REQ-023 HOLD: rsp_valid=1; rsp_ack=1 -> IDLE; buffers retain data (no buf_clr).
REQ-024 Timeout counter SHALL increment each COLLECT cycle without transfer, zero on transfer; reaching TIMEOUT -> ABORT.
REQ-025 Transfer in the same cycle the counter reaches TIMEOUT SHALL win: byte accepted, no abort.
REQ-026 ABORT: buf_clr=1 and err=1 for one cycle -> IDLE.
REQ-027 buf_ld and buf_clr SHALL never be high in the same cycle; buf_ld at most one bit high.
REQ-028 Latency: last transfer at cycle T -> buf_ld at T+1 -> buffer Q valid and rsp_valid=1 at T+2.
REQ-029 rsp_ack outside HOLD SHALL be ignored; byte_valid outside COLLECT SHALL not be consumed.
REQ-030 buf_d SHALL hold its last value when buf_ld is all-zero.

Reset
REQ-031 clr=1 at any posedge SHALL force IDLE, idx=0, timeout counter=0, buf_d=0, buf_ld=0, rsp_valid=0, err=0, busy=0, byte_ready=0.
REQ-032 buf_clr SHALL be 1 for the cycle following reset release is NOT required; buf_clr=0 in reset; buffers are cleared by the next CLEAR state.
REQ-033 clr mid-COLLECT SHALL discard the partial response with no err pulse.

Structure
REQ-034 State encoding, default NUM_BUF and TIMEOUT SHALL live in shared package puf_pkg.
REQ-035 Optional single sub-module puf_timeout_cnt (load-zero/increment/terminal flag); buffers instantiated outside this block.

Verification
REQ-036 clr, start, bytes 0xA5,0x3C,0x0F,0xF0 back-to-back -> buf_ld 0001,0010,0100,1000 with buf_d matching; rsp_valid two cycles after last transfer; buffers read F0_0F_3C_A5.
REQ-037 TIMEOUT=4, start, one byte 0x11, then byte_valid=0 -> after 4 idle cycles buf_clr=1, err=1 once, busy=0 next cycle.
REQ-038 byte_valid toggling 1,0,1,0 with bytes 0x01..0x04 and timeout not reached -> all four captured, no err.
REQ-039 Transfer on exact terminal-count cycle (TIMEOUT=4) -> byte loaded, no ABORT.
REQ-040 clr asserted after second byte -> IDLE next cycle, buf_ld=0, err=0; new start then completes normally.
REQ-041 start and rsp_ack held high in HOLD -> one IDLE cycle, then CLEAR with buf_clr pulse; rsp_valid low from IDLE onward.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared types and defaults for the PUF response sequencer.
package puf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_COLLECT = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_HOLD    = 3'd4,
    ST_ABORT   = 3'd5
  } state_e;

  localparam int NUM_BUF_DEF = 4;
  localparam int TIMEOUT_DEF = 255;
  localparam int CNT_W       = 16;

endpackage

// File: rtl/puf_timeout_cnt.sv
// Idle-cycle counter for the byte-gap watchdog; term flags the TIMEOUT-th idle cycle.
module puf_timeout_cnt
  import puf_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic clr,
  input  logic load_zero,
  input  logic inc,
  output logic term
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_zero) cnt_d = '0;
    else if (inc)  cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Asserted while the current cycle would be the TIMEOUT-th consecutive idle one.
  assign term = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/puf_resp_sequencer.sv
// Sequences PUF response bytes into NUM_BUF external byte buffers.
//   state      | meaning
//   ST_IDLE    | waiting for start
//   ST_CLEAR   | clear buffers, reset byte index and watchdog
//   ST_COLLECT | accepting bytes; watchdog counting idle cycles
//   ST_SETTLE  | final load strobe in flight
//   ST_HOLD    | response valid until rsp_ack
//   ST_ABORT   | watchdog expired: clear buffers, pulse err
module puf_resp_sequencer
  import puf_pkg::*;
#(
  parameter int NUM_BUF = NUM_BUF_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic [7:0]         buf_d,
  output logic [NUM_BUF-1:0] buf_ld,
  output logic               buf_clr,
  output logic               rsp_valid,
  input  logic               rsp_ack,
  output logic               busy,
  output logic               err
);

  localparam int IDX_W = $clog2(NUM_BUF);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         bus_q, bus_d;
  logic [NUM_BUF-1:0] ld_q, ld_d;
  logic               in_collect, xfer, to_term;

  assign in_collect = (state_q == ST_COLLECT);
  assign xfer       = in_collect & byte_valid;

  puf_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk       (clk),
    .clr       (clr),
    .load_zero (~in_collect | xfer),
    .inc       (in_collect & ~xfer),
    .term      (to_term)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      bus_q   <= '0;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bus_q   <= bus_d;
      ld_q    <= ld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bus_d   = bus_q;
    ld_d    = '0;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_CLEAR;
      ST_CLEAR: begin
        idx_d   = '0;
        state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        // A byte arriving on the terminal cycle still counts, so xfer is checked first.
        if (xfer) begin
          bus_d = byte_in;
          ld_d  = NUM_BUF'(1) << idx_q;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NUM_BUF - 1)) state_d = ST_SETTLE;
        end else if (to_term) begin
          state_d = ST_ABORT;
        end
      end
      ST_SETTLE:  state_d = ST_HOLD;
      ST_HOLD:    if (rsp_ack) state_d = ST_IDLE;
      ST_ABORT:   state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    buf_clr    = 1'b0;
    rsp_valid  = 1'b0;
    err        = 1'b0;
    busy       = (state_q != ST_IDLE);
    case (state_q)
      ST_CLEAR:   buf_clr    = 1'b1;
      ST_COLLECT: byte_ready = 1'b1;
      ST_HOLD:    rsp_valid  = 1'b1;
      ST_ABORT: begin
        buf_clr = 1'b1;
        err     = 1'b1;
      end
      default: ;
    endcase
  end

  assign buf_d  = bus_q;
  assign buf_ld = ld_q;

endmodule
